// File: rtl/snn_ff_syn_pkg.sv
// Shared constants for the synapse read-modify-write sweep controller:
// FSM state encoding and the depth of the read-to-write-back pipeline.
package snn_ff_syn_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_SWEEP = 2'd1;
    localparam fsm_state_t ST_DRAIN = 2'd2;
    localparam fsm_state_t ST_DONE  = 2'd3;

    // One cycle of SRAM read latency plus one register stage in the update unit.
    localparam int PIPE_DEPTH = 2;

endpackage : snn_ff_syn_pkg

// File: rtl/rmw_delay_line.sv
// Valid/data shift register that carries each issued read address forward
// to the cycle its updated word is written back.
module rmw_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             pending
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // NOTE: the address stages are reset along with the valids because the
    // write address is observable on the port and must read 0 during reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    // Entries still upstream of the output stage.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | valid_q[i];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule : rmw_delay_line

// File: rtl/synapse_rmw_ctrl.sv
// Sweeps the synapse SRAM once per tref event: reads every address in order
// and writes back the update unit's {weight, gradient} two cycles later.
module synapse_rmw_ctrl
    import snn_ff_syn_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_SYN      = 1024,
    parameter int WEIGHT_WIDTH = 8,
    parameter int GRAD_WIDTH   = 8
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               CTRL_TREF_EVENT,
    input  logic                               HOLD,
    output logic                               SRAM_RE,
    output logic [ADDR_WIDTH-1:0]              SRAM_RADDR,
    output logic                               SRAM_WE,
    output logic [ADDR_WIDTH-1:0]              SRAM_WADDR,
    input  logic [WEIGHT_WIDTH-1:0]            WSYN_NEW,
    input  logic [GRAD_WIDTH-1:0]              GRAD_NEW,
    output logic [WEIGHT_WIDTH+GRAD_WIDTH-1:0] SRAM_WDATA,
    output logic                               UPD_EVENT,
    output logic                               BUSY,
    output logic                               DONE
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_SYN - 1);

    fsm_state_t            state_q;
    fsm_state_t            state_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q;

    logic                  rd_issue;
    logic                  rd_last;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  pipe_pending;

    assign rd_issue = (state_q == ST_SWEEP) && !HOLD;
    assign rd_last  = rd_issue && (rd_cnt_q == LAST_ADDR);

    // NOTE: every output of this block gets a default before the case, so no
    // path through it leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (CTRL_TREF_EVENT) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (rd_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once only the output stage can still hold an entry:
                // that last write happens now and DONE lands right after it.
                if (!pipe_pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its inputs from the same pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && CTRL_TREF_EVENT) begin
                rd_cnt_q <= '0;
            end else if (rd_issue && !rd_last) begin
                rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    rmw_delay_line #(
        .DEPTH (PIPE_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_delay_line (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (rd_issue),
        .in_data   (rd_cnt_q),
        .out_valid (wr_valid),
        .out_data  (wr_addr),
        .pending   (pipe_pending)
    );

    assign SRAM_RE    = rd_issue;
    assign SRAM_RADDR = rd_cnt_q;
    assign SRAM_WE    = wr_valid;
    assign UPD_EVENT  = wr_valid;
    assign SRAM_WADDR = wr_addr;
    // Gated so the bus stays quiet on bubbles and during reset.
    assign SRAM_WDATA = wr_valid ? {WSYN_NEW, GRAD_NEW} : '0;
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = (state_q == ST_DONE);

    // The two-cycle read/write offset means the two ports never collide.
    a_no_port_collision: assert property (
        @(posedge CLK) disable iff (!RST_N)
        (SRAM_RE && SRAM_WE) |-> (SRAM_RADDR != SRAM_WADDR)
    );

    a_no_write_in_idle: assert property (
        @(posedge CLK) disable iff (!RST_N)
        (state_q == ST_IDLE) |-> !SRAM_WE
    );

endmodule : synapse_rmw_ctrl
